// File: rtl/idp_operand_stage.sv
// idp_operand_stage
//   Operand-fetch / write-back stage that sits directly in front of alu16.
//   It holds a 2**AW x DW register file and issues registered R/S/Alu_Op.
//   On the edge after an operation issues, it writes the alu16 result back
//   into the register file and updates the status register.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   in_valid / in_ready   instruction handshake (in_ready = ~hold)
//   hold                  downstream stall; freezes the whole stage
//   R_Adr, S_Adr, S_Sel   operand sources (S_Sel=1 selects the DS immediate)
//   DS                    immediate data
//   Op_In                 ALU opcode
//   W_En, W_Adr           write-back enable and destination register
//   F_En                  status-flag update enable
//   R, S, Alu_Op          registered operands and opcode to alu16
//   op_valid              R/S/Alu_Op hold a live operation
//   Y, N, Z, C            combinational result and flags from alu16
//   Stat                  status register {N,Z,C}
//   dbg_adr, dbg_data     debug read port; raw array value, never bypassed
module idp_operand_stage #(
  parameter int DW = 16,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          hold,
  input  logic [AW-1:0] R_Adr,
  input  logic [AW-1:0] S_Adr,
  input  logic          S_Sel,
  input  logic [DW-1:0] DS,
  input  logic [3:0]    Op_In,
  input  logic          W_En,
  input  logic [AW-1:0] W_Adr,
  input  logic          F_En,
  output logic [DW-1:0] R,
  output logic [DW-1:0] S,
  output logic [3:0]    Alu_Op,
  output logic          op_valid,
  input  logic [DW-1:0] Y,
  input  logic          N,
  input  logic          Z,
  input  logic          C,
  output logic [2:0]    Stat,
  input  logic [AW-1:0] dbg_adr,
  output logic [DW-1:0] dbg_data
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0][DW-1:0] rf_q;
  logic [DW-1:0]           r_q, s_q;
  logic [3:0]              op_q;
  logic                    vld_q;
  logic                    wen_q, fen_q;
  logic [AW-1:0]           wadr_q;
  logic [2:0]              stat_q;

  logic                    wb_live;
  logic [DW-1:0]           r_d, s_d, s_rd;

  // The in-flight result is not in the array yet, so a reader of its
  // destination takes Y directly. R and S forward independently.
  assign wb_live = vld_q & wen_q;

  always_comb begin
    r_d  = (wb_live && (wadr_q == R_Adr)) ? Y : rf_q[R_Adr];
    s_rd = (wb_live && (wadr_q == S_Adr)) ? Y : rf_q[S_Adr];
    s_d  = S_Sel ? DS : s_rd;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_q   <= '0;
      r_q    <= '0;
      s_q    <= '0;
      op_q   <= '0;
      vld_q  <= 1'b0;
      wen_q  <= 1'b0;
      fen_q  <= 1'b0;
      wadr_q <= '0;
      stat_q <= '0;
    end else if (!hold) begin
      // Retire the operation currently presented to alu16.
      if (vld_q) begin
        if (wen_q) rf_q[wadr_q] <= Y;
        if (fen_q) stat_q <= {N, Z, C};
      end
      vld_q <= in_valid;
      // Operands persist across idle cycles; only an accept reloads them.
      if (in_valid) begin
        r_q    <= r_d;
        s_q    <= s_d;
        op_q   <= Op_In;
        wen_q  <= W_En;
        wadr_q <= W_Adr;
        fen_q  <= F_En;
      end
    end
  end

  assign in_ready = ~hold;
  assign R        = r_q;
  assign S        = s_q;
  assign Alu_Op   = op_q;
  assign op_valid = vld_q;
  assign Stat     = stat_q;
  assign dbg_data = rf_q[dbg_adr];

endmodule

// File: tb/tb_idp_operand_stage.sv
module tb_idp_operand_stage;
  localparam int DW = 16;
  localparam int AW = 3;
  localparam int NREG = 8;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, hold, S_Sel, W_En, F_En;
  logic [AW-1:0] R_Adr, S_Adr, W_Adr, dbg_adr;
  logic [DW-1:0] DS, R, S, Y, dbg_data;
  logic [3:0]    Op_In, Alu_Op;
  logic          op_valid, N, Z, C;
  logic [2:0]    Stat;

  always #10 clk = ~clk;

  idp_operand_stage #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .hold(hold), .R_Adr(R_Adr), .S_Adr(S_Adr), .S_Sel(S_Sel), .DS(DS),
    .Op_In(Op_In), .W_En(W_En), .W_Adr(W_Adr), .F_En(F_En),
    .R(R), .S(S), .Alu_Op(Alu_Op), .op_valid(op_valid),
    .Y(Y), .N(N), .Z(Z), .C(C), .Stat(Stat),
    .dbg_adr(dbg_adr), .dbg_data(dbg_data)
  );

  // Stand-in alu16: returns {N,Z,C,Y}.
  function automatic logic [18:0] alu(input logic [15:0] r, s, input logic [3:0] op);
    logic [16:0] w;
    w = '0;
    case (op)
      4'd0: w = {1'b0, s};
      4'd1: w = {1'b0, r};
      4'd2: w = {1'b0, r} + {1'b0, s};
      4'd3: w = {1'b0, r} - {1'b0, s};
      4'd4: w = {1'b0, r & s};
      4'd5: w = {1'b0, r | s};
      4'd6: w = {1'b0, r ^ s};
      default: w = {1'b0, ~r};
    endcase
    return {w[15], (w[15:0] == 16'h0), w[16], w[15:0]};
  endfunction

  always_comb begin
    logic [18:0] t;
    t = alu(R, S, Alu_Op);
    {N, Z, C, Y} = t;
  end

  int checks = 0;
  int errors = 0;

  // Architectural reference: instructions applied in program order.
  logic [DW-1:0] mrf [NREG];
  logic [2:0]    mstat;
  logic [DW-1:0] exp_R, exp_S;
  logic [3:0]    exp_op;
  logic          exp_ov;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check("R", 32'(R), 32'(exp_R));
    check("S", 32'(S), 32'(exp_S));
    check("Alu_Op", 32'(Alu_Op), 32'(exp_op));
    check("op_valid", 32'(op_valid), 32'(exp_ov));
    check("in_ready", 32'(in_ready), 32'(!hold));
  endtask

  task automatic issue(input logic [2:0] radr, sadr, input logic ssel, input logic [15:0] ds,
                       input logic [3:0] op, input logic wen, input logic [2:0] wadr,
                       input logic fen);
    logic [15:0] r, s;
    logic [18:0] res;
    in_valid = 1'b1; hold = 1'b0;
    R_Adr = radr; S_Adr = sadr; S_Sel = ssel; DS = ds; Op_In = op;
    W_En = wen; W_Adr = wadr; F_En = fen;
    r = mrf[radr];
    s = ssel ? ds : mrf[sadr];
    res = alu(r, s, op);
    if (wen) mrf[wadr] = res[15:0];
    if (fen) mstat = res[18:16];
    exp_R = r; exp_S = s; exp_op = op; exp_ov = 1'b1;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0; hold = 1'b0;
    R_Adr = 3'($urandom); S_Adr = 3'($urandom); DS = 16'($urandom);
    Op_In = 4'($urandom); W_En = 1'($urandom); F_En = 1'($urandom);
    exp_ov = 1'b0;
    tick();
  endtask

  // Stall cycle; inputs are junk that must be ignored.
  task automatic stall();
    hold = 1'b1; in_valid = 1'($urandom);
    R_Adr = 3'($urandom); S_Adr = 3'($urandom); S_Sel = 1'($urandom);
    DS = 16'($urandom); Op_In = 4'($urandom); W_En = 1'($urandom);
    W_Adr = 3'($urandom); F_En = 1'($urandom);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0;
    for (int i = 0; i < NREG; i++) mrf[i] = '0;
    mstat = '0; exp_R = '0; exp_S = '0; exp_op = '0; exp_ov = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Only meaningful when nothing is in flight.
  task automatic check_arch();
    for (int i = 0; i < NREG; i++) begin
      dbg_adr = 3'(i);
      #1;
      check("dbg_data", 32'(dbg_data), 32'(mrf[i]));
    end
    check("Stat", 32'(Stat), 32'(mstat));
  endtask

  initial begin
    logic [15:0] old7;
    int pick;
    reset = 1'b1; in_valid = 1'b0; hold = 1'b0; S_Sel = 1'b0; W_En = 1'b0; F_En = 1'b0;
    R_Adr = '0; S_Adr = '0; W_Adr = '0; dbg_adr = '0; DS = '0; Op_In = '0;
    do_reset();
    check_arch();

    // Immediate load into r3.
    issue(0, 0, 1, 16'hAA55, 0, 1, 3, 0);
    check("t1_S", 32'(S), 32'h0000AA55);
    idle();
    dbg_adr = 3; #1;
    check("t1_r3", 32'(dbg_data), 32'h0000AA55);
    check_arch();

    // Register operands, S path forwarded from the previous write.
    issue(0, 0, 1, 16'hCCCC, 0, 1, 1, 0);
    issue(0, 0, 1, 16'h3333, 0, 1, 2, 0);
    issue(1, 2, 0, 16'h0000, 1, 1, 4, 0);
    check("t2_R", 32'(R), 32'h0000CCCC);
    check("t2_S", 32'(S), 32'h00003333);
    check("t2_op", 32'(Alu_Op), 32'h1);
    idle();
    check_arch();

    // Back-to-back dependency on the R path.
    issue(0, 0, 1, 16'h00FF, 0, 1, 5, 0);
    issue(5, 0, 0, 16'h0000, 1, 1, 6, 0);
    check("t3_R", 32'(R), 32'h000000FF);
    idle();
    check_arch();

    // Flags: zero result sets Z; F_En=0 leaves Stat alone.
    issue(0, 0, 1, 16'h0000, 0, 0, 0, 1);
    issue(0, 0, 1, 16'h8000, 0, 0, 0, 0);
    idle();
    check("t4_stat", 32'(Stat), 32'h2);
    check_arch();

    // Stall with a write to r7 pending.
    old7 = mrf[7];
    issue(0, 0, 1, 16'h1234, 0, 1, 7, 0);
    for (int i = 0; i < 3; i++) begin
      stall();
      dbg_adr = 7; #1;
      check("t5_r7_held", 32'(dbg_data), 32'(old7));
    end
    idle();
    dbg_adr = 7; #1;
    check("t5_r7", 32'(dbg_data), 32'h00001234);
    idle();
    check_arch();

    // Reset discards the in-flight write and flag update.
    issue(0, 0, 1, 16'hBEEF, 0, 1, 0, 1);
    do_reset();
    check_arch();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 19));
      if (pick < 13)
        issue(3'($urandom), 3'($urandom), 1'($urandom), 16'($urandom), 4'($urandom_range(0, 8)),
              1'($urandom), 3'($urandom), 1'($urandom));
      else if (pick < 16)
        stall();
      else if (pick < 19) begin
        idle();
        check_arch();
      end else begin
        do_reset();
        check_arch();
      end
    end
    idle();
    check_arch();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
